// File: rtl/cp0_defs.sv
// Shared definitions for the CP0 register file.
// Holds the (addr, sel) codes of every implemented register, the Status/Cause
// bit positions, the MTC0 write masks, the reset values and a decoder that
// maps an (addr, sel) pair onto a register identifier.
package cp0_defs;

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_COUNT    = 5'd9;
    localparam logic [4:0] ADDR_ENTRYHI  = 5'd10;
    localparam logic [4:0] ADDR_COMPARE  = 5'd11;
    localparam logic [4:0] ADDR_STATUS   = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_EBASE    = 5'd15;
    localparam logic [2:0] SEL_0         = 3'd0;
    localparam logic [2:0] SEL_EBASE     = 3'd1;

    // Status bit positions
    localparam int STATUS_BEV = 22;
    localparam int STATUS_IM_HI = 15;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_IE  = 0;

    // Cause bit positions
    localparam int CAUSE_BD = 31;
    localparam int CAUSE_TI = 30;
    localparam int CAUSE_IV = 23;

    // MTC0 write masks (1 = software writable)
    localparam logic [31:0] STATUS_WMASK  = 32'h0040_FF03;
    localparam logic [31:0] EBASE_WMASK   = 32'h3FFF_F000;
    localparam logic [31:0] ENTRYHI_WMASK = 32'hFFFF_E0FF;

    // Reset values
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] EBASE_RESET  = 32'h8000_0000;

    typedef enum logic [3:0] {
        REG_NONE,
        REG_BADVADDR,
        REG_COUNT,
        REG_ENTRYHI,
        REG_COMPARE,
        REG_STATUS,
        REG_CAUSE,
        REG_EPC,
        REG_EBASE
    } cp0_reg_e;

    function automatic cp0_reg_e cp0_decode(input logic [4:0] addr, input logic [2:0] sel);
        cp0_reg_e r;
        r = REG_NONE;
        case ({addr, sel})
            {ADDR_BADVADDR, SEL_0}:     r = REG_BADVADDR;
            {ADDR_COUNT,    SEL_0}:     r = REG_COUNT;
            {ADDR_ENTRYHI,  SEL_0}:     r = REG_ENTRYHI;
            {ADDR_COMPARE,  SEL_0}:     r = REG_COMPARE;
            {ADDR_STATUS,   SEL_0}:     r = REG_STATUS;
            {ADDR_CAUSE,    SEL_0}:     r = REG_CAUSE;
            {ADDR_EPC,      SEL_0}:     r = REG_EPC;
            {ADDR_EBASE,    SEL_EBASE}: r = REG_EBASE;
            default:                    r = REG_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer.
// Count advances once every two cycles using a one-bit phase; loading Count
// restarts the phase. timer_pending latches the cycle after Count == Compare
// (Compare nonzero) and is cleared only by a write to Compare.
// Ports: clk, rst (sync, active-high); count_we_i / compare_we_i with wdata_i
// load the registers; count_o, compare_o, timer_pending_o expose state.
module cp0_timer
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_pending_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        phase_q, phase_d;
    logic        pending_q, pending_d;

    always_comb begin
        count_d   = count_q;
        phase_d   = ~phase_q;
        compare_d = compare_q;
        pending_d = pending_q | ((count_q == compare_q) && (compare_q != 32'd0));
        // Natural 32-bit wrap; no overflow side effect.
        if (phase_q) begin
            count_d = count_q + 32'd1;
        end
        if (count_we_i) begin
            count_d = wdata_i;
            phase_d = 1'b0;
        end
        if (compare_we_i) begin
            compare_d = wdata_i;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            phase_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
        end
    end

    assign count_o         = count_q;
    assign compare_o       = compare_q;
    assign timer_pending_o = pending_q;

endmodule

// File: rtl/cp0_regs.sv
// CP0 system-control register file.
// MTC0 writes (we/waddr/wsel/wdata) and combinational MFC0 reads
// (raddr/rsel/rdata); exception commit (cp0_in_exp, cp0_clean_exl, exp_*),
// memory-fault capture (cp0_badv_we, cp0_exp_asid_we), raw interrupt lines
// (hw_int_in) and a set of registered-state status outputs for the pipeline.
// Exception-side updates are applied after MTC0 so they win on shared fields.
module cp0_regs
    import cp0_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [2:0]  wsel,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    input  logic [2:0]  rsel,
    output logic [31:0] rdata,
    input  logic [5:0]  hw_int_in,
    input  logic        cp0_in_exp,
    input  logic        cp0_clean_exl,
    input  logic [31:0] exp_epc,
    input  logic [4:0]  exp_code,
    input  logic        in_delayslot,
    input  logic [31:0] exp_bad_vaddr,
    input  logic        cp0_badv_we,
    input  logic [7:0]  exp_asid,
    input  logic        cp0_exp_asid_we,
    output logic [7:0]  interrupt_mask,
    output logic [5:0]  hardware_int,
    output logic [1:0]  software_int,
    output logic        allow_int,
    output logic        special_int_vec,
    output logic        boot_exp_vec,
    output logic        exl,
    output logic [19:0] ebase_out,
    output logic [31:0] epc_out,
    output logic [7:0]  asid_out
);

    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] entryhi_q, entryhi_d;
    logic [31:0] ebase_q, ebase_d;
    logic        bd_q, bd_d;
    logic        iv_q, iv_d;
    logic [5:0]  ip_hw_q, ip_hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;

    logic [31:0] count, compare;
    logic        timer_pending;
    logic [31:0] cause;
    cp0_reg_e    wr_reg, rd_reg;

    assign wr_reg = we ? cp0_decode(waddr, wsel) : REG_NONE;
    assign rd_reg = cp0_decode(raddr, rsel);

    cp0_timer u_timer (
        .clk             (clk),
        .rst             (rst),
        .count_we_i      (wr_reg == REG_COUNT),
        .compare_we_i    (wr_reg == REG_COMPARE),
        .wdata_i         (wdata),
        .count_o         (count),
        .compare_o       (compare),
        .timer_pending_o (timer_pending)
    );

    assign cause = {bd_q, timer_pending, 6'b0, iv_q, 7'b0, ip_hw_q, ip_sw_q,
                    1'b0, exccode_q, 2'b0};

    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        entryhi_d  = entryhi_q;
        ebase_d    = ebase_q;
        bd_d       = bd_q;
        iv_d       = iv_q;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        // Hardware IP is resampled every cycle; the timer shares line 7.
        ip_hw_d    = {hw_int_in[5] | timer_pending, hw_int_in[4:0]};

        case (wr_reg)
            REG_STATUS:  status_d  = (status_q & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
            REG_CAUSE: begin
                iv_d    = wdata[CAUSE_IV];
                ip_sw_d = wdata[9:8];
            end
            REG_EPC:     epc_d     = wdata;
            REG_EBASE:   ebase_d   = (ebase_q & ~EBASE_WMASK) | (wdata & EBASE_WMASK);
            REG_ENTRYHI: entryhi_d = (entryhi_q & ~ENTRYHI_WMASK) | (wdata & ENTRYHI_WMASK);
            default: ;
        endcase

        // A nested exception (EXL already set) keeps the original EPC/BD.
        if (cp0_in_exp) begin
            exccode_d            = exp_code;
            status_d[STATUS_EXL] = 1'b1;
            if (!status_q[STATUS_EXL]) begin
                epc_d = exp_epc;
                bd_d  = in_delayslot;
            end
        end else if (cp0_clean_exl) begin
            status_d[STATUS_EXL] = 1'b0;
        end

        if (cp0_badv_we) begin
            badvaddr_d = exp_bad_vaddr;
        end
        if (cp0_exp_asid_we) begin
            entryhi_d = {exp_bad_vaddr[31:13], 5'b0, exp_asid};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RESET;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            entryhi_q  <= 32'd0;
            ebase_q    <= EBASE_RESET;
            bd_q       <= 1'b0;
            iv_q       <= 1'b0;
            ip_hw_q    <= 6'd0;
            ip_sw_q    <= 2'd0;
            exccode_q  <= 5'd0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            entryhi_q  <= entryhi_d;
            ebase_q    <= ebase_d;
            bd_q       <= bd_d;
            iv_q       <= iv_d;
            ip_hw_q    <= ip_hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (rd_reg)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count;
            REG_ENTRYHI:  rdata = entryhi_q;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = status_q;
            REG_CAUSE:    rdata = cause;
            REG_EPC:      rdata = epc_q;
            REG_EBASE:    rdata = ebase_q;
            default:      rdata = 32'd0;
        endcase
    end

    assign interrupt_mask  = status_q[STATUS_IM_HI:STATUS_IM_LO];
    assign hardware_int    = ip_hw_q;
    assign software_int    = ip_sw_q;
    assign allow_int       = status_q[STATUS_IE] & ~status_q[STATUS_EXL];
    assign special_int_vec = iv_q;
    assign boot_exp_vec    = status_q[STATUS_BEV];
    assign exl             = status_q[STATUS_EXL];
    assign ebase_out       = ebase_q[31:12];
    assign epc_out         = epc_q;
    assign asid_out        = entryhi_q[7:0];

endmodule
